// File: rtl/dot_product_feeder_if.sv
// Stream, BRAM-write and macro-operand signals of dot_product_feeder.
// Signal names are seen from the feeder: i_* enter it, o_* leave it.
interface dot_product_feeder_if #(
   parameter int N       = 8,
   parameter int M       = 16,
   parameter int MB      = 8,
   parameter int A       = 10,
   parameter int FIFO_AW = 5
);
   logic                 i_load_start;
   logic [A:0]           i_load_words;
   logic [MB*N-1:0]      i_coef_data;
   logic                 i_coef_valid;
   logic                 o_coef_ready;
   logic [M*N-1:0]       i_a_data;
   logic                 i_a_valid;
   logic                 o_a_ready;
   logic [FIFO_AW:0]     i_vec_len;
   logic [MB*N-1:0]      o_b;
   logic [A-1:0]         o_b_addr;
   logic                 o_wren;
   logic [M*N-1:0]       o_a;
   logic                 o_first;
   logic                 o_last;
   logic                 o_busy;
   logic                 o_err;

   modport slave (
      input  i_load_start, i_load_words, i_coef_data, i_coef_valid,
      input  i_a_data, i_a_valid, i_vec_len,
      output o_coef_ready, o_a_ready, o_b, o_b_addr, o_wren,
      output o_a, o_first, o_last, o_busy, o_err
   );

   modport master (
      output i_load_start, i_load_words, i_coef_data, i_coef_valid,
      output i_a_data, i_a_valid, i_vec_len,
      input  o_coef_ready, o_a_ready, o_b, o_b_addr, o_wren,
      input  o_a, o_first, o_last, o_busy, o_err
   );
endinterface

// File: rtl/dot_product_feeder.sv
// Loads coefficients into the dot-product macro BRAM and streams buffered A beats
// as gap-free framed bursts. Define DOT_FEEDER_BACK2BACK_EN to chain bursts without idle cycles.
module dot_product_feeder #(
   parameter int N       = 8,
   parameter int M       = 16,
   parameter int MB      = 8,
   parameter int A       = 10,
   parameter int FIFO_AW = 5
) (
   input logic                 i_clk,
   input logic                 i_reset,
   dot_product_feeder_if.slave bus
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [A:0]         REM_ONE  = (A + 1)'(1);
   localparam logic [A-1:0]       ADR_ONE  = A'(1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

   state_t               r_state;
   logic [M*N-1:0]       r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wptr;
   logic [FIFO_AW-1:0]   r_rptr;
   logic [FIFO_AW:0]     r_count;
   logic                 r_a_ready;
   logic [A-1:0]         r_waddr;
   logic [A:0]           r_remain;
   logic [FIFO_AW:0]     r_beats;
   logic                 r_first_pend;
   logic                 r_coef_ready;
   logic [MB*N-1:0]      r_b;
   logic [A-1:0]         r_b_addr;
   logic                 r_wren;
   logic [M*N-1:0]       r_a;
   logic                 r_first;
   logic                 r_last;
   logic                 r_busy;
   logic                 r_err;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_accept;
   logic [FIFO_AW:0]     w_count_next;
   logic [FIFO_AW:0]     w_vl;

   // Zero-length bursts become single beats; anything beyond the FIFO depth is clamped.
   function automatic logic [FIFO_AW:0] eff_len(input logic [FIFO_AW:0] v);
      if (v == '0)
         return CNT_ONE;
      else if (v > CNT_FULL)
         return CNT_FULL;
      else
         return v;
   endfunction

   assign w_push   = bus.i_a_valid & r_a_ready;
   assign w_pop    = (r_state == STREAM);
   assign w_accept = bus.i_coef_valid & r_coef_ready;
   assign w_vl     = eff_len(bus.i_vec_len);

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + CNT_ONE;
      else if (w_pop && !w_push)
         w_count_next = r_count - CNT_ONE;
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wptr] <= bus.i_a_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_a_ready    <= 1'b0;
         r_waddr      <= '0;
         r_remain     <= '0;
         r_beats      <= '0;
         r_first_pend <= 1'b0;
         r_coef_ready <= 1'b0;
         r_b          <= '0;
         r_b_addr     <= '0;
         r_wren       <= 1'b0;
         r_a          <= '0;
         r_first      <= 1'b0;
         r_last       <= 1'b0;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_count   <= w_count_next;
         r_a_ready <= (w_count_next < CNT_FULL);
         if (w_push)
            r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)
            r_rptr <= r_rptr + PTR_ONE;

         r_wren  <= 1'b0;
         r_a     <= '0;
         r_first <= 1'b0;
         r_last  <= 1'b0;

         if (bus.i_load_start && r_state != IDLE)
            r_err <= 1'b1;

         case (r_state)
            IDLE: begin
               if (bus.i_load_start) begin
                  if (bus.i_load_words != '0) begin
                     r_state      <= LOAD;
                     r_waddr      <= '0;
                     r_remain     <= bus.i_load_words;
                     r_coef_ready <= 1'b1;
                     r_busy       <= 1'b1;
                  end
               end else if (r_count >= w_vl) begin
                  r_state      <= STREAM;
                  r_beats      <= w_vl;
                  r_first_pend <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            LOAD: begin
               if (w_accept) begin
                  r_wren   <= 1'b1;
                  r_b      <= bus.i_coef_data;
                  r_b_addr <= r_waddr;
                  r_waddr  <= r_waddr + ADR_ONE;
                  r_remain <= r_remain - REM_ONE;
                  if (r_remain == REM_ONE) begin
                     r_state      <= IDLE;
                     r_coef_ready <= 1'b0;
                     r_busy       <= 1'b0;
                  end
               end
            end
            STREAM: begin
               // Pop is unconditional: entry required the FIFO to hold the whole burst.
               r_a          <= r_mem[r_rptr];
               r_first      <= r_first_pend;
               r_first_pend <= 1'b0;
               r_last       <= (r_beats == CNT_ONE);
               r_beats      <= r_beats - CNT_ONE;
               if (r_beats == CNT_ONE) begin
`ifdef DOT_FEEDER_BACK2BACK_EN
                  if (!bus.i_load_start && w_count_next >= w_vl) begin
                     r_beats      <= w_vl;
                     r_first_pend <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
`else
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
`endif
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_coef_ready = r_coef_ready;
   assign bus.o_a_ready    = r_a_ready;
   assign bus.o_b          = r_b;
   assign bus.o_b_addr     = r_b_addr;
   assign bus.o_wren       = r_wren;
   assign bus.o_a          = r_a;
   assign bus.o_first      = r_first;
   assign bus.o_last       = r_last;
   assign bus.o_busy       = r_busy;
   assign bus.o_err        = r_err;
endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder: table of burst cases plus hand sequences
// for load, full FIFO during load, ignored start, chained bursts and mid-burst reset.
module tb_dot_product_feeder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   dot_product_feeder_if #(.N(8), .M(16), .MB(8), .A(10), .FIFO_AW(5)) bus ();

   dot_product_feeder #(.N(8), .M(16), .MB(8), .A(10), .FIFO_AW(5)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [5:0] vec_len;
      int         npush;
      int         exp_len;
      logic [7:0] base;
   } burst_t;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] beat(input logic [7:0] v);
      logic [127:0] b;
      for (int l = 0; l < 16; l++)
         b[l*8 +: 8] = v + 8'(l * 17);
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] v);
      bit ok;
      int b;
      bus.i_a_data  = beat(v);
      bus.i_a_valid = 1'b1;
      b = 0;
      forever begin
         ok = bus.o_a_ready;
         tick();
         b++;
         if (ok) break;
         if (b > 100) begin
            chk("push_timeout", 128'(0), 128'(1));
            break;
         end
      end
      bus.i_a_valid = 1'b0;
   endtask

   task automatic wait_first(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!bus.o_first && lat < 100);
      if (!bus.o_first)
         chk("first_timeout", 128'(bus.o_first), 128'(1));
   endtask

   // Called with beat 0 of a burst visible; leaves the bench on the cycle after o_last.
   task automatic check_burst(input string nm, input int len, input logic [7:0] base);
      for (int k = 0; k < len; k++) begin
         chk({nm, "_a"}, bus.o_a, beat(base + 8'(k)));
         chk({nm, "_first"}, 128'(bus.o_first), 128'(k == 0));
         chk({nm, "_last"}, 128'(bus.o_last), 128'(k == len - 1));
         tick();
      end
   endtask

   initial begin
      burst_t       tbl[4];
      logic [63:0]  coef[5];
      int           lat;

      tbl[0] = '{vec_len: 6'd4,  npush: 4,  exp_len: 4,  base: 8'h01};
      tbl[1] = '{vec_len: 6'd0,  npush: 1,  exp_len: 1,  base: 8'h10};
      tbl[2] = '{vec_len: 6'd2,  npush: 2,  exp_len: 2,  base: 8'h20};
      tbl[3] = '{vec_len: 6'd40, npush: 32, exp_len: 32, base: 8'hA0};
      coef[0] = 64'h1111111111111111;
      coef[1] = 64'h2222222222222222;
      coef[2] = 64'h3333333333333333;
      coef[3] = 64'h4444444444444444;
      coef[4] = 64'h5555555555555555;

      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.i_load_start = 1'b0;
      bus.i_load_words = '0;
      bus.i_coef_data  = '0;
      bus.i_coef_valid = 1'b0;
      bus.i_a_data     = '0;
      bus.i_a_valid    = 1'b0;
      bus.i_vec_len    = 6'd4;

      // Reset state
      tick();
      tick();
      chk("rst_wren", 128'(bus.o_wren), 128'(0));
      chk("rst_a", bus.o_a, 128'(0));
      chk("rst_busy", 128'(bus.o_busy), 128'(0));
      chk("rst_err", 128'(bus.o_err), 128'(0));
      chk("rst_coef_ready", 128'(bus.o_coef_ready), 128'(0));
      chk("rst_a_ready", 128'(bus.o_a_ready), 128'(0));
      rst = 1'b0;
      tick();
      chk("post_rst_a_ready", 128'(bus.o_a_ready), 128'(1));

      // Coefficient load of 3 words, valid held high
      bus.i_load_start = 1'b1;
      bus.i_load_words = 11'd3;
      bus.i_coef_valid = 1'b1;
      bus.i_coef_data  = coef[0];
      tick();
      bus.i_load_start = 1'b0;
      chk("load_coef_ready", 128'(bus.o_coef_ready), 128'(1));
      chk("load_busy", 128'(bus.o_busy), 128'(1));
      chk("load_no_wren_yet", 128'(bus.o_wren), 128'(0));
      for (int k = 0; k < 3; k++) begin
         bus.i_coef_data = coef[k];
         tick();
         chk("load_wren", 128'(bus.o_wren), 128'(1));
         chk("load_addr", 128'(bus.o_b_addr), 128'(k));
         chk("load_b", 128'(bus.o_b), 128'(coef[k]));
      end
      chk("load_done_busy", 128'(bus.o_busy), 128'(0));
      chk("load_done_ready", 128'(bus.o_coef_ready), 128'(0));
      tick();
      chk("load_done_wren", 128'(bus.o_wren), 128'(0));
      bus.i_coef_valid = 1'b0;

      // Table of single bursts
      for (int t = 0; t < 4; t++) begin
         bus.i_vec_len = tbl[t].vec_len;
         for (int k = 0; k < tbl[t].npush; k++)
            push(tbl[t].base + 8'(k));
         wait_first(lat);
         chk("tbl_latency", 128'(lat), 128'(2));
         check_burst("tbl", tbl[t].exp_len, tbl[t].base);
         chk("tbl_gap_first", 128'(bus.o_first), 128'(0));
         chk("tbl_gap_a", bus.o_a, 128'(0));
         chk("tbl_gap_busy", 128'(bus.o_busy), 128'(0));
      end

      // Two single-beat bursts
      bus.i_vec_len = 6'd1;
      push(8'h50);
      push(8'h51);
      wait_first(lat);
      chk("pair0_a", bus.o_a, beat(8'h50));
      chk("pair0_last", 128'(bus.o_last), 128'(1));
      tick();
`ifdef DOT_FEEDER_BACK2BACK_EN
      chk("pair1_first", 128'(bus.o_first), 128'(1));
      chk("pair1_last", 128'(bus.o_last), 128'(1));
      chk("pair1_a", bus.o_a, beat(8'h51));
`else
      chk("pair_gap_first", 128'(bus.o_first), 128'(0));
      chk("pair_gap_a", bus.o_a, 128'(0));
      tick();
      chk("pair1_first", 128'(bus.o_first), 128'(1));
      chk("pair1_last", 128'(bus.o_last), 128'(1));
      chk("pair1_a", bus.o_a, beat(8'h51));
`endif
      tick();
      chk("pair_end_first", 128'(bus.o_first), 128'(0));

      // Fill the FIFO while a load is pending, then complete the load
      bus.i_vec_len    = 6'd32;
      bus.i_load_start = 1'b1;
      bus.i_load_words = 11'd5;
      tick();
      bus.i_load_start = 1'b0;
      for (int k = 0; k < 32; k++)
         push(8'h80 + 8'(k));
      chk("full_a_ready", 128'(bus.o_a_ready), 128'(0));
      chk("full_busy", 128'(bus.o_busy), 128'(1));
      chk("full_no_first", 128'(bus.o_first), 128'(0));
      bus.i_a_data  = beat(8'hEE);
      bus.i_a_valid = 1'b1;
      tick();
      tick();
      chk("full_still_not_ready", 128'(bus.o_a_ready), 128'(0));
      bus.i_a_valid = 1'b0;
      bus.i_coef_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.i_coef_data = coef[k];
         tick();
         chk("full_load_wren", 128'(bus.o_wren), 128'(1));
         chk("full_load_addr", 128'(bus.o_b_addr), 128'(k));
         chk("full_load_b", 128'(bus.o_b), 128'(coef[k]));
      end
      bus.i_coef_valid = 1'b0;
      wait_first(lat);
      chk("full_latency", 128'(lat), 128'(2));
      check_burst("full", 32, 8'h80);
      chk("full_gap_first", 128'(bus.o_first), 128'(0));
      chk("full_ready_back", 128'(bus.o_a_ready), 128'(1));

      // Start during a burst is ignored and flagged
      bus.i_vec_len = 6'd4;
      for (int k = 0; k < 4; k++)
         push(8'hC0 + 8'(k));
      wait_first(lat);
      bus.i_load_start = 1'b1;
      bus.i_load_words = 11'd2;
      bus.i_coef_valid = 1'b1;
      bus.i_coef_data  = coef[4];
      tick();
      bus.i_load_start = 1'b0;
      chk("err_set", 128'(bus.o_err), 128'(1));
      chk("err_beat1", bus.o_a, beat(8'hC1));
      chk("err_coef_ready", 128'(bus.o_coef_ready), 128'(0));
      for (int k = 0; k < 6; k++) begin
         chk("err_no_wren", 128'(bus.o_wren), 128'(0));
         tick();
      end
      bus.i_coef_valid = 1'b0;
      chk("err_sticky", 128'(bus.o_err), 128'(1));
      chk("err_idle", 128'(bus.o_busy), 128'(0));

      // Reset in the middle of an 8-beat burst
      bus.i_vec_len = 6'd8;
      for (int k = 0; k < 8; k++)
         push(8'h60 + 8'(k));
      wait_first(lat);
      tick();
      chk("mid_beat1", bus.o_a, beat(8'h61));
      rst = 1'b1;
      tick();
      chk("mid_rst_a", bus.o_a, 128'(0));
      chk("mid_rst_first", 128'(bus.o_first), 128'(0));
      chk("mid_rst_last", 128'(bus.o_last), 128'(0));
      chk("mid_rst_busy", 128'(bus.o_busy), 128'(0));
      chk("mid_rst_err", 128'(bus.o_err), 128'(0));
      chk("mid_rst_wren", 128'(bus.o_wren), 128'(0));
      rst = 1'b0;
      tick();
      chk("mid_ready", 128'(bus.o_a_ready), 128'(1));
      for (int k = 0; k < 7; k++)
         push(8'h70 + 8'(k));
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mid_wait_first", 128'(bus.o_first), 128'(0));
         chk("mid_wait_busy", 128'(bus.o_busy), 128'(0));
      end
      push(8'h77);
      wait_first(lat);
      chk("mid_latency", 128'(lat), 128'(2));
      check_burst("mid_new", 8, 8'h70);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
